// File: rtl/gif_panel_scan.sv
`timescale 1ns/1ps
// gif_panel_scan
// Reads dual-pixel words from the GIF frame memory and drives a HUB75-style
// 64x64 LED panel. It scans 32 row pairs with 4-plane binary-code modulation.
// The animation frame advances after a set number of complete refreshes.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   play                   1 = advance animation frames, 0 = hold frame
//   address, frame_sel, rd memory read request ({row,col}, frame, strobe)
//   rdata                  memory data, valid the cycle after rd
//                          [23:12] upper pixel, [11:0] lower pixel, {R,G,B} nibbles
//   r0,g0,b0 / r1,g1,b1    upper / lower half colour bits for the current plane
//   row_addr               panel row-pair select
//   panel_clk, latch, oe_n panel shift clock, latch strobe, output enable (low)
//   frame_done             one-cycle pulse when frame_sel advances
module gif_panel_scan #(
  parameter int WIDTH             = 11,
  parameter int COLS              = 64,
  parameter int ROWS              = 32,
  parameter int BASE_ON           = 16,
  parameter int REFRESH_PER_FRAME = 30,
  parameter int NUM_FRAMES        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play,
  output logic [WIDTH-1:0] address,
  output logic [1:0]       frame_sel,
  output logic             rd,
  input  logic [23:0]      rdata,
  output logic             r0,
  output logic             g0,
  output logic             b0,
  output logic             r1,
  output logic             g1,
  output logic             b1,
  output logic [4:0]       row_addr,
  output logic             panel_clk,
  output logic             latch,
  output logic             oe_n,
  output logic             frame_done
);

  typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_t;

  localparam logic [5:0]  COL_LAST   = 6'(COLS - 1);
  localparam logic [4:0]  ROW_LAST   = 5'(ROWS - 1);
  localparam logic [15:0] RPF_LAST   = 16'(REFRESH_PER_FRAME - 1);
  localparam logic [1:0]  FRAME_LAST = 2'(NUM_FRAMES - 1);

  // State and counters describe the step the next clock edge issues, so every
  // output is registered directly from the next-value logic below.
  state_t      state, state_nx;
  logic [1:0]  ph, ph_nx;
  logic [5:0]  col, col_nx;
  logic [4:0]  row, row_nx;
  logic [1:0]  plane, plane_nx;
  logic [15:0] dcnt, dcnt_nx;
  logic [15:0] rcnt, rcnt_nx;
  logic        wrap_pend, wrap_nx;

  logic [WIDTH-1:0] address_nx;
  logic [1:0]       frame_sel_nx;
  logic             rd_nx, frame_done_nx, panel_clk_nx, latch_nx, oe_n_nx;
  logic [5:0]       rgb, rgb_nx;
  logic [4:0]       row_addr_nx;

  assign {r0, g0, b0, r1, g1, b1} = rgb;

  always_comb begin
    state_nx      = state;
    ph_nx         = ph;
    col_nx        = col;
    row_nx        = row;
    plane_nx      = plane;
    dcnt_nx       = dcnt;
    rcnt_nx       = rcnt;
    wrap_nx       = wrap_pend;
    address_nx    = address;
    frame_sel_nx  = frame_sel;
    rd_nx         = 1'b0;
    frame_done_nx = 1'b0;
    rgb_nx        = rgb;
    row_addr_nx   = row_addr;
    panel_clk_nx  = 1'b0;
    latch_nx      = 1'b0;
    oe_n_nx       = 1'b1;

    unique case (state)
      SHIFT: begin
        unique case (ph)
          2'd0: begin
            rd_nx        = 1'b1;
            address_nx   = WIDTH'({row, col});
            // Shift clock for the previous column rises with this read.
            panel_clk_nx = (col != 6'd0);
            ph_nx        = 2'd1;
            // A refresh finished on the last DISPLAY; the frame switches
            // here so it lines up with the first read of the new refresh.
            if (wrap_pend) begin
              wrap_nx = 1'b0;
              if (play) begin
                if (rcnt == RPF_LAST) begin
                  rcnt_nx       = '0;
                  frame_sel_nx  = (frame_sel == FRAME_LAST) ? 2'd0 : frame_sel + 2'd1;
                  frame_done_nx = 1'b1;
                end else begin
                  rcnt_nx = rcnt + 16'd1;
                end
              end
            end
          end
          2'd1: ph_nx = 2'd2;
          default: begin
            // Bit index {nibble, plane} selects bit 'plane' of each colour nibble.
            rgb_nx = {rdata[{3'd5, plane}], rdata[{3'd4, plane}], rdata[{3'd3, plane}],
                      rdata[{3'd2, plane}], rdata[{3'd1, plane}], rdata[{3'd0, plane}]};
            ph_nx  = 2'd0;
            if (col == COL_LAST) begin
              col_nx   = '0;
              state_nx = BLANK;
            end else begin
              col_nx = col + 6'd1;
            end
          end
        endcase
      end
      BLANK: begin
        panel_clk_nx = 1'b1;
        state_nx     = LATCH;
      end
      LATCH: begin
        latch_nx    = 1'b1;
        row_addr_nx = row;
        dcnt_nx     = (16'(BASE_ON) << plane) - 16'd1;
        state_nx    = DISPLAY;
      end
      default: begin
        oe_n_nx = 1'b0;
        if (dcnt == 16'd0) begin
          state_nx = SHIFT;
          plane_nx = plane + 2'd1;
          if (plane == 2'd3) begin
            if (row == ROW_LAST) begin
              row_nx  = '0;
              wrap_nx = 1'b1;
            end else begin
              row_nx = row + 5'd1;
            end
          end
        end else begin
          dcnt_nx = dcnt - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SHIFT;
      ph         <= '0;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      dcnt       <= '0;
      rcnt       <= '0;
      wrap_pend  <= 1'b0;
      address    <= '0;
      frame_sel  <= '0;
      rd         <= 1'b0;
      frame_done <= 1'b0;
      rgb        <= '0;
      row_addr   <= '0;
      panel_clk  <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
    end else begin
      state      <= state_nx;
      ph         <= ph_nx;
      col        <= col_nx;
      row        <= row_nx;
      plane      <= plane_nx;
      dcnt       <= dcnt_nx;
      rcnt       <= rcnt_nx;
      wrap_pend  <= wrap_nx;
      address    <= address_nx;
      frame_sel  <= frame_sel_nx;
      rd         <= rd_nx;
      frame_done <= frame_done_nx;
      rgb        <= rgb_nx;
      row_addr   <= row_addr_nx;
      panel_clk  <= panel_clk_nx;
      latch      <= latch_nx;
      oe_n       <= oe_n_nx;
    end
  end

endmodule
